lfsr_checker: RTL and testbench

LFSR_CHECKER -- requirements
Module: lfsr_checker

---
 rtl/lfsr_pkg.sv | 22 ++
 rtl/lfsr_checker_sat_counter.sv | 41 ++++
 rtl/lfsr_checker.sv | 137 +++++++++++++
 tb/tb_lfsr_checker.sv | 383 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lfsr_pkg.sv
// Shared LFSR definitions: word width, feedback taps, next-state function, checker states.
// Latency: n/a (package only).
// Backpressure: n/a; the generator and the checker both import this package.
package lfsr_pkg;

    localparam int LFSR_W = 5;
    localparam int TAP_A  = 0;
    localparam int TAP_B  = 3;

    typedef enum logic [1:0] {
        ST_SEARCH = 2'd0,
        ST_VERIFY = 2'd1,
        ST_LOCKED = 2'd2
    } chk_state_e;

    // Right-shifting Fibonacci LFSR; the taps give a period-31 sequence
    // over the nonzero words. All-zero is the lock-up state.
    function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] w);
        return {w[TAP_A] ^ w[TAP_B], w[LFSR_W-1:1]};
    endfunction

endpackage

// File: rtl/lfsr_checker_sat_counter.sv
// Saturating up-counter with synchronous clear; a clear and an increment in the same cycle load 1.
// Latency: count reflects clr/inc one cycle after they are presented.
// Backpressure: none; holds at all-ones instead of wrapping.
//
// Ports: clk, rst (async active-low), clr, inc, count[W-1:0].
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr && inc) begin
            // The clear wipes history but the event in this cycle still counts.
            count_d = W'(1);
        end else if (clr) begin
            count_d = '0;
        end else if (inc && (count_q != {W{1'b1}})) begin
            count_d = count_q + W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/lfsr_checker.sv
// Locks onto a received 5-bit LFSR state stream, then flags and counts words that break the sequence.
// Latency: all outputs registered, one cycle after the sampled word.
// Backpressure: none; in_valid=0 cycles simply hold state.
//
// Ports: clk, rst (async active-low), in_valid, in_data[4:0], clr_cnt,
//        locked, err_pulse, zero_err, err_count[15:0].
module lfsr_checker
    import lfsr_pkg::*;
#(
    parameter int LOCK_CNT = 4,
    parameter int LOSS_CNT = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [LFSR_W-1:0] in_data,
    input  logic              clr_cnt,
    output logic              locked,
    output logic              err_pulse,
    output logic              zero_err,
    output logic [15:0]       err_count
);

    localparam logic [3:0] LOCK_CNT_W = 4'(LOCK_CNT);
    localparam logic [3:0] LOSS_CNT_W = 4'(LOSS_CNT);

    chk_state_e        state_q,     state_d;
    logic [LFSR_W-1:0] expected_q,  expected_d;
    logic [3:0]        good_q,      good_d;
    logic [3:0]        bad_q,       bad_d;
    logic              locked_q,    locked_d;
    logic              err_pulse_q, err_pulse_d;
    logic              zero_err_q,  zero_err_d;
    logic              err_inc;
    logic              is_zero;
    logic              is_match;

    assign is_zero  = (in_data == '0);
    assign is_match = (in_data == expected_q);

    always_comb begin
        state_d     = state_q;
        expected_d  = expected_q;
        good_d      = good_q;
        bad_d       = bad_q;
        err_pulse_d = 1'b0;
        zero_err_d  = 1'b0;
        err_inc     = 1'b0;

        if (in_valid) begin
            zero_err_d = is_zero;
            unique case (state_q)
                ST_SEARCH: begin
                    if (!is_zero) begin
                        expected_d = lfsr_next(in_data);
                        good_d     = 4'd1;
                        state_d    = ST_VERIFY;
                    end
                end
                ST_VERIFY: begin
                    if (is_zero) begin
                        state_d = ST_SEARCH;
                    end else begin
                        expected_d = lfsr_next(in_data);
                        if (is_match) begin
                            // The seed word sets good=1, so a match seen
                            // while good==LOCK_CNT is the LOCK_CNT-th match.
                            if (good_q == LOCK_CNT_W) begin
                                state_d = ST_LOCKED;
                                bad_d   = 4'd0;
                            end else begin
                                good_d = good_q + 4'd1;
                            end
                        end else begin
                            good_d = 4'd1;
                        end
                    end
                end
                ST_LOCKED: begin
                    // Free-running prediction: a corrupted word must not
                    // derail the reference sequence.
                    expected_d = lfsr_next(expected_q);
                    if (is_match) begin
                        bad_d = 4'd0;
                    end else begin
                        err_pulse_d = 1'b1;
                        err_inc     = 1'b1;
                        bad_d       = bad_q + 4'd1;
                        if ((bad_q + 4'd1) == LOSS_CNT_W) begin
                            state_d = ST_SEARCH;
                        end
                    end
                end
                default: begin
                    state_d = ST_SEARCH;
                end
            endcase
        end

        locked_d = (state_d == ST_LOCKED);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_SEARCH;
            expected_q  <= '0;
            good_q      <= 4'd0;
            bad_q       <= 4'd0;
            locked_q    <= 1'b0;
            err_pulse_q <= 1'b0;
            zero_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            expected_q  <= expected_d;
            good_q      <= good_d;
            bad_q       <= bad_d;
            locked_q    <= locked_d;
            err_pulse_q <= err_pulse_d;
            zero_err_q  <= zero_err_d;
        end
    end

    sat_counter #(
        .W (16)
    ) u_err_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (clr_cnt),
        .inc   (err_inc),
        .count (err_count)
    );

    assign locked    = locked_q;
    assign err_pulse = err_pulse_q;
    assign zero_err  = zero_err_q;

endmodule

// File: tb/tb_lfsr_checker.sv
// Scoreboard bench for lfsr_checker: a behavioural model pushes expected outputs per driven cycle.
// Latency: expects outputs one cycle after each driven word.
// Backpressure: n/a.
module tb_lfsr_checker;

    localparam int LOCK_CNT = 4;
    localparam int LOSS_CNT = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [4:0]  in_data;
    logic        clr_cnt;
    logic        locked;
    logic        err_pulse;
    logic        zero_err;
    logic [15:0] err_count;

    always #5 clk = ~clk;

    lfsr_checker #(
        .LOCK_CNT (LOCK_CNT),
        .LOSS_CNT (LOSS_CNT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .clr_cnt   (clr_cnt),
        .locked    (locked),
        .err_pulse (err_pulse),
        .zero_err  (zero_err),
        .err_count (err_count)
    );

    typedef struct packed {
        logic        locked;
        logic        err_pulse;
        logic        zero_err;
        logic [15:0] cnt;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model state: 0=search, 1=verify, 2=locked.
    int          m_state;
    logic [4:0]  m_exp;
    int          m_match;
    int          m_bad;
    logic [15:0] m_cnt;

    logic [4:0] lock_words [5] = '{5'b10101, 5'b11010, 5'b11101, 5'b01110, 5'b10111};

    function automatic logic [4:0] nxt(input logic [4:0] w);
        return {w[0] ^ w[3], w[4:1]};
    endfunction

    function automatic void model_reset();
        m_state = 0;
        m_exp   = 5'd0;
        m_match = 0;
        m_bad   = 0;
        m_cnt   = 16'd0;
        sb_q.delete();
    endfunction

    function automatic exp_t model_step(input logic v, input logic [4:0] d, input logic c);
        exp_t r;
        logic inc;
        r   = '0;
        inc = 1'b0;
        if (v) begin
            r.zero_err = (d == 5'd0);
            if (m_state == 0) begin
                if (d != 5'd0) begin
                    m_exp   = nxt(d);
                    m_match = 0;
                    m_state = 1;
                end
            end else if (m_state == 1) begin
                if (d == 5'd0) begin
                    m_state = 0;
                end else if (d == m_exp) begin
                    m_exp   = nxt(d);
                    m_match = m_match + 1;
                    if (m_match == LOCK_CNT) begin
                        m_state = 2;
                        m_bad   = 0;
                    end
                end else begin
                    m_exp   = nxt(d);
                    m_match = 0;
                end
            end else begin
                if (d != m_exp) begin
                    inc         = 1'b1;
                    r.err_pulse = 1'b1;
                    m_bad       = m_bad + 1;
                    if (m_bad == LOSS_CNT) m_state = 0;
                end else begin
                    m_bad = 0;
                end
                m_exp = nxt(m_exp);
            end
        end
        if (c && inc)                          m_cnt = 16'd1;
        else if (c)                            m_cnt = 16'd0;
        else if (inc && m_cnt != 16'hFFFF)     m_cnt = m_cnt + 16'd1;
        r.locked = (m_state == 2);
        r.cnt    = m_cnt;
        return r;
    endfunction

    task automatic drive(input logic v, input logic [4:0] d, input logic c);
        @(negedge clk);
        in_valid = v;
        in_data  = d;
        clr_cnt  = c;
        sb_q.push_back(model_step(v, d, c));
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        clr_cnt  = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_reset();
        rst      = 1'b0;
        in_valid = 1'b0;
        in_data  = 5'd0;
        clr_cnt  = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({locked, err_pulse, zero_err, err_count} !== 19'd0) begin
            errors++;
            $display("FAIL reset_state: got %b/%b/%b/%h want 0/0/0/0000", locked, err_pulse, zero_err, err_count);
        end
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_lock();
        exp_t e;
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, lock_words[i], 1'b0);
            e = sb_q.pop_front();
            checks++;
            if ({locked, err_pulse, zero_err, err_count} !== e) begin
                errors++;
                $display("FAIL lock_seq[%0d]: got %b/%b/%b/%h want %b/%b/%b/%h", i, locked, err_pulse, zero_err, err_count, e.locked, e.err_pulse, e.zero_err, e.cnt);
            end
        end
        checks++;
        if (locked !== 1'b1 || err_count !== 16'd0) begin
            errors++;
            $display("FAIL lock_after_10111: got locked=%b cnt=%h want 1/0000", locked, err_count);
        end
    endtask

    task automatic test_single_err();
        exp_t e;
        for (int i = 0; i < 31 && m_exp != 5'b11010; i++) begin
            drive(1'b1, m_exp, 1'b0);
            e = sb_q.pop_front();
            checks++;
            if ({locked, err_pulse, zero_err, err_count} !== e) begin
                errors++;
                $display("FAIL single_err_pre[%0d]: got %b/%b/%b/%h want %b/%b/%b/%h", i, locked, err_pulse, zero_err, err_count, e.locked, e.err_pulse, e.zero_err, e.cnt);
            end
        end
        drive(1'b1, 5'b11011, 1'b0);
        e = sb_q.pop_front();
        checks++;
        if ({locked, err_pulse, zero_err, err_count} !== e) begin
            errors++;
            $display("FAIL single_err_word: got %b/%b/%b/%h want %b/%b/%b/%h", locked, err_pulse, zero_err, err_count, e.locked, e.err_pulse, e.zero_err, e.cnt);
        end
        checks++;
        if (err_pulse !== 1'b1 || err_count !== 16'd1 || locked !== 1'b1) begin
            errors++;
            $display("FAIL single_err_flags: got pulse=%b cnt=%h locked=%b want 1/0001/1", err_pulse, err_count, locked);
        end
        drive(1'b1, 5'b11101, 1'b0);
        e = sb_q.pop_front();
        checks++;
        if (err_pulse !== 1'b0 || locked !== 1'b1 || {locked, err_pulse, zero_err, err_count} !== e) begin
            errors++;
            $display("FAIL single_err_freerun: got pulse=%b locked=%b cnt=%h want 0/1/%h", err_pulse, locked, err_count, e.cnt);
        end
    endtask

    task automatic test_loss_relock();
        exp_t e;
        logic [4:0] s;
        drive(1'b0, 5'd0, 1'b1);
        e = sb_q.pop_front();
        checks++;
        if (err_count !== 16'd0 || {locked, err_pulse, zero_err, err_count} !== e) begin
            errors++;
            $display("FAIL clr_alone: got cnt=%h want 0000", err_count);
        end
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, m_exp ^ 5'b10000, 1'b0);
            e = sb_q.pop_front();
            checks++;
            if ({locked, err_pulse, zero_err, err_count} !== e) begin
                errors++;
                $display("FAIL loss_err[%0d]: got %b/%b/%b/%h want %b/%b/%b/%h", i, locked, err_pulse, zero_err, err_count, e.locked, e.err_pulse, e.zero_err, e.cnt);
            end
        end
        checks++;
        if (err_count !== 16'd3 || locked !== 1'b0) begin
            errors++;
            $display("FAIL loss_final: got cnt=%h locked=%b want 0003/0", err_count, locked);
        end
        s = 5'b00101;
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, s, 1'b0);
            e = sb_q.pop_front();
            checks++;
            if ({locked, err_pulse, zero_err, err_count} !== e) begin
                errors++;
                $display("FAIL relock[%0d]: got %b/%b/%b/%h want %b/%b/%b/%h", i, locked, err_pulse, zero_err, err_count, e.locked, e.err_pulse, e.zero_err, e.cnt);
            end
            if (i == 0) begin
                checks++;
                if (locked !== 1'b0) begin
                    errors++;
                    $display("FAIL relock_seed: got locked=%b want 0", locked);
                end
            end
            s = nxt(s);
        end
        checks++;
        if (locked !== 1'b1) begin
            errors++;
            $display("FAIL relock_final: got locked=%b want 1", locked);
        end
    endtask

    task automatic test_sparse();
        exp_t e;
        logic [4:0] lk;
        int k;
        do_reset();
        lk = '0;
        k  = 0;
        for (int i = 0; i < 10; i++) begin
            if (i % 2 == 0) drive(1'b0, 5'b11111, 1'b0);
            else            drive(1'b1, lock_words[i/2], 1'b0);
            e = sb_q.pop_front();
            checks++;
            if ({locked, err_pulse, zero_err, err_count} !== e) begin
                errors++;
                $display("FAIL sparse[%0d]: got %b/%b/%b/%h want %b/%b/%b/%h", i, locked, err_pulse, zero_err, err_count, e.locked, e.err_pulse, e.zero_err, e.cnt);
            end
            if (i % 2 == 1) begin
                lk[k] = locked;
                k++;
            end
        end
        checks++;
        if (lk !== 5'b10000) begin
            errors++;
            $display("FAIL sparse_lock_pattern: got %b want 10000", lk);
        end
    endtask

    task automatic test_saturate();
        exp_t e;
        @(negedge clk);
        force dut.u_err_cnt.count_q = 16'hFFFE;
        #1;
        release dut.u_err_cnt.count_q;
        m_cnt = 16'hFFFE;
        for (int i = 0; i < 5; i++) begin
            if (i % 2 == 0) drive(1'b1, m_exp ^ 5'b00100, 1'b0);
            else            drive(1'b1, m_exp, 1'b0);
            e = sb_q.pop_front();
            checks++;
            if ({locked, err_pulse, zero_err, err_count} !== e) begin
                errors++;
                $display("FAIL saturate[%0d]: got %b/%b/%b/%h want %b/%b/%b/%h", i, locked, err_pulse, zero_err, err_count, e.locked, e.err_pulse, e.zero_err, e.cnt);
            end
        end
        checks++;
        if (err_count !== 16'hFFFF || locked !== 1'b1) begin
            errors++;
            $display("FAIL saturate_hold: got cnt=%h locked=%b want ffff/1", err_count, locked);
        end
        drive(1'b1, m_exp ^ 5'b00001, 1'b1);
        e = sb_q.pop_front();
        checks++;
        if (err_count !== 16'd1 || err_pulse !== 1'b1 || {locked, err_pulse, zero_err, err_count} !== e) begin
            errors++;
            $display("FAIL clr_with_err: got cnt=%h pulse=%b want 0001/1", err_count, err_pulse);
        end
    endtask

    task automatic test_zero_and_reset();
        exp_t e;
        do_reset();
        drive(1'b1, 5'd0, 1'b0);
        e = sb_q.pop_front();
        checks++;
        if (zero_err !== 1'b1 || locked !== 1'b0 || {locked, err_pulse, zero_err, err_count} !== e) begin
            errors++;
            $display("FAIL zero_in_search: got zero=%b locked=%b want 1/0", zero_err, locked);
        end
        drive(1'b0, 5'd0, 1'b0);
        e = sb_q.pop_front();
        checks++;
        if (zero_err !== 1'b0 || {locked, err_pulse, zero_err, err_count} !== e) begin
            errors++;
            $display("FAIL zero_strobe_len: got zero=%b want 0", zero_err);
        end
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, lock_words[i], 1'b0);
            e = sb_q.pop_front();
            checks++;
            if ({locked, err_pulse, zero_err, err_count} !== e) begin
                errors++;
                $display("FAIL zero_then_lock[%0d]: got %b/%b/%b/%h want %b/%b/%b/%h", i, locked, err_pulse, zero_err, err_count, e.locked, e.err_pulse, e.zero_err, e.cnt);
            end
        end
        drive(1'b1, m_exp ^ 5'b01000, 1'b0);
        e = sb_q.pop_front();
        checks++;
        if ({locked, err_pulse, err_count} !== 18'h30001 || {locked, err_pulse, zero_err, err_count} !== e) begin
            errors++;
            $display("FAIL pre_reset_state: got locked=%b pulse=%b cnt=%h want 1/1/0001", locked, err_pulse, err_count);
        end
        @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if ({locked, err_pulse, zero_err, err_count} !== 19'd0) begin
            errors++;
            $display("FAIL async_reset: got %b/%b/%b/%h want 0/0/0/0000", locked, err_pulse, zero_err, err_count);
        end
        model_reset();
        @(negedge clk);
        rst = 1'b1;
        drive(1'b1, lock_words[1], 1'b0);
        e = sb_q.pop_front();
        checks++;
        if (locked !== 1'b0 || {locked, err_pulse, zero_err, err_count} !== e) begin
            errors++;
            $display("FAIL history_discarded: got locked=%b cnt=%h want 0/0000", locked, err_count);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time budget");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_lock();
        test_single_err();
        test_loss_relock();
        test_sparse();
        test_saturate();
        test_zero_and_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
